// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes: single-cycle logic/arith/compare
// ops plus iterative shift-add MUL and restoring DIV/REM sharing one datapath.
module seq_alu #(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       func,
  input  logic [WIDTH-1:0] dataIn1,
  input  logic [WIDTH-1:0] dataIn2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataOut,
  output logic             compTrue,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             cmp_q, cmp_d;
  logic             dz_q, dz_d;
  logic [4:0]       func_q, func_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d;

  logic             accept, is_multi, is_mul, is_rem;
  logic [WIDTH-1:0] sc_res;
  logic             sc_cmp, lt, eq, zero, neg;
  logic [WIDTH-1:0] mul_acc, div_acc, div_x;
  logic [WIDTH:0]   r_sh, r_diff;
  logic             r_ge;

  // Single-cycle result, computed straight from the request operands
  always_comb begin
    sc_res = '0;
    sc_cmp = 1'b0;
    lt     = SIGNED_CMP ? ($signed(dataIn1) < $signed(dataIn2)) : (dataIn1 < dataIn2);
    eq     = (dataIn1 == dataIn2);
    zero   = (dataIn1 == '0);
    neg    = SIGNED_CMP && dataIn1[WIDTH-1];
    case (func)
      5'b00000: sc_res = dataIn1 + dataIn2;
      5'b00001: sc_res = dataIn1 - dataIn2;
      5'b00100: sc_res = dataIn1 & dataIn2;
      5'b00101: sc_res = dataIn1 | dataIn2;
      5'b00110: sc_res = dataIn1 ^ dataIn2;
      5'b01100: sc_res = ~(dataIn1 & dataIn2);
      5'b01101: sc_res = ~(dataIn1 | dataIn2);
      5'b01110: sc_res = ~(dataIn1 ^ dataIn2);
      5'b01011: sc_res = {dataIn2[WIDTH-1:WIDTH/2], {(WIDTH/2){1'b0}}};
      5'b11000: sc_cmp = 1'b1;
      5'b10001: sc_cmp = eq;
      5'b10010: sc_cmp = lt;
      5'b10011: sc_cmp = lt || eq;
      5'b11001: sc_cmp = !eq;
      5'b11010: sc_cmp = !lt;
      5'b11011: sc_cmp = !lt && !eq;
      5'b10101: sc_cmp = zero;
      5'b10110: sc_cmp = neg;
      5'b10111: sc_cmp = neg || zero;
      5'b11101: sc_cmp = !zero;
      5'b11110: sc_cmp = !neg;
      5'b11111: sc_cmp = !neg && !zero;
      default:  sc_res = '0;
    endcase
    if (func[4]) sc_res = WIDTH'(sc_cmp);
  end

  // One iteration of multiply (x=multiplicand, y=multiplier) or
  // divide (x=dividend shifting into quotient, y=divisor, acc=partial remainder)
  always_comb begin
    mul_acc = y_q[0] ? (acc_q + x_q) : acc_q;
    r_sh    = {acc_q, x_q[WIDTH-1]};
    r_diff  = r_sh - {1'b0, y_q};
    r_ge    = (r_sh >= {1'b0, y_q});
    div_acc = r_ge ? r_diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    div_x   = {x_q[WIDTH-2:0], r_ge};
  end

  assign is_multi  = (func == 5'b00010) || (func == 5'b00011) || (func == 5'b00111);
  assign is_mul    = (func_q == 5'b00010);
  assign is_rem    = (func_q == 5'b00111);
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign dataOut   = dout_q;
  assign compTrue  = cmp_q;
  assign div_zero  = dz_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    cmp_d   = cmp_q;
    dz_d    = dz_q;
    func_d  = func_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    case (state_q)
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (is_mul) begin
          acc_d = mul_acc;
          x_d   = {x_q[WIDTH-2:0], 1'b0};
          y_d   = {1'b0, y_q[WIDTH-1:1]};
        end else begin
          acc_d = div_acc;
          x_d   = div_x;
        end
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          dout_d  = is_mul ? mul_acc : (is_rem ? div_acc : div_x);
          cmp_d   = 1'b0;
          dz_d    = !is_mul && (y_q == '0);
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = state_q;
    endcase
    // A DONE-state accept overrides the return to IDLE for back-to-back issue
    if (accept) begin
      if (is_multi) begin
        state_d = BUSY;
        cnt_d   = CW'(WIDTH);
        func_d  = func;
        x_d     = dataIn1;
        y_d     = dataIn2;
        acc_d   = '0;
      end else begin
        state_d = DONE;
        dout_d  = sc_res;
        cmp_d   = sc_cmp;
        dz_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      cmp_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      cmp_q   <= cmp_d;
      dz_q    <= dz_d;
    end
  end

  always_ff @(posedge clk) begin
    func_q <= func_d;
    x_q    <= x_d;
    y_q    <= y_d;
    acc_q  <= acc_d;
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table of ops plus hand-written
// sequences for reset, streaming, stalls and operand capture.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic [4:0]  func;
  logic [31:0] dataIn1, dataIn2;
  logic        in_ready, out_valid, compTrue, div_zero;
  logic [31:0] dataOut;
  logic        u_in_ready, u_out_valid, u_compTrue, u_div_zero;
  logic [31:0] u_dataOut;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32), .SIGNED_CMP(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .dataIn1(dataIn1), .dataIn2(dataIn2), .out_valid(out_valid),
    .out_ready(out_ready), .dataOut(dataOut), .compTrue(compTrue), .div_zero(div_zero)
  );

  seq_alu #(.WIDTH(32), .SIGNED_CMP(1'b0)) dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u_in_ready),
    .func(func), .dataIn1(dataIn1), .dataIn2(dataIn2), .out_valid(u_out_valid),
    .out_ready(out_ready), .dataOut(u_dataOut), .compTrue(u_compTrue), .div_zero(u_div_zero)
  );

  typedef struct {
    logic [4:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        c;
    logic        cu;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] d, input logic c, input logic cu,
                     input logic dz, input int lat);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.d = d; v.c = c; v.cu = cu; v.dz = dz; v.lat = lat;
    vq.push_back(v);
  endtask

  // Issue one op from IDLE, wait for the result with a bounded loop, then drain it
  task automatic run_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] d, output logic c, output logic cu,
                        output logic dz, output int lat, output bit busy_rdy);
    @(negedge clk);
    func = f; dataIn1 = a; dataIn2 = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    busy_rdy = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_rdy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    d = dataOut; c = compTrue; cu = u_compTrue; dz = div_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        c, cu, dz;
    int          lat, n;
    bit          br;

    //   func      a             b             data          c     cu    dz    lat
    add(5'b00000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0, 1);
    add(5'b00001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1);
    add(5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1);
    add(5'b00101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 1);
    add(5'b00110, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1);
    add(5'b01100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0, 1'b0, 1'b0, 1);
    add(5'b01101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0, 1'b0, 1);
    add(5'b01110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 1'b0, 1'b0, 1'b0, 1);
    add(5'b01011, 32'h00000000, 32'h1234ABCD, 32'h12340000, 1'b0, 1'b0, 1'b0, 1);
    add(5'b10000, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0, 1);
    add(5'b11000, 32'h00000000, 32'h00000001, 32'h00000001, 1'b1, 1'b1, 1'b0, 1);
    add(5'b10001, 32'h00000007, 32'h00000007, 32'h00000001, 1'b1, 1'b1, 1'b0, 1);
    add(5'b11001, 32'h00000007, 32'h00000007, 32'h00000000, 1'b0, 1'b0, 1'b0, 1);
    add(5'b10010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0, 1);
    add(5'b10011, 32'h00000005, 32'h00000005, 32'h00000001, 1'b1, 1'b1, 1'b0, 1);
    add(5'b11011, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 1);
    add(5'b11010, 32'h00000003, 32'h00000004, 32'h00000000, 1'b0, 1'b0, 1'b0, 1);
    add(5'b10110, 32'h80000000, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 1);
    add(5'b10111, 32'h80000000, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 1);
    add(5'b10101, 32'h00000000, 32'h00000005, 32'h00000001, 1'b1, 1'b1, 1'b0, 1);
    add(5'b11101, 32'h00000000, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1'b0, 1);
    add(5'b11110, 32'h00000000, 32'h00000000, 32'h00000001, 1'b1, 1'b1, 1'b0, 1);
    add(5'b11111, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1);
    add(5'b01000, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1);
    add(5'b10100, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1);
    add(5'b00010, 32'h00010003, 32'h00010002, 32'h00050006, 1'b0, 1'b0, 1'b0, 33);
    add(5'b00010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 33);
    add(5'b00011, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 1'b0, 33);
    add(5'b00111, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 1'b0, 33);
    add(5'b00011, 32'hFFFFFFFF, 32'd3,        32'h55555555, 1'b0, 1'b0, 1'b0, 33);
    add(5'b00111, 32'hFFFFFFFF, 32'd10,       32'd5,        1'b0, 1'b0, 1'b0, 33);
    add(5'b00011, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 33);
    add(5'b00111, 32'd5,        32'd0,        32'd5,        1'b0, 1'b0, 1'b1, 33);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    func = '0; dataIn1 = '0; dataIn2 = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dataOut", dataOut, 32'd0);
    chk("rst_compTrue", 32'(compTrue), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      run_op(vq[i].f, vq[i].a, vq[i].b, d, c, cu, dz, lat, br);
      chk($sformatf("v%0d_data", i), d, vq[i].d);
      chk($sformatf("v%0d_cmp", i), 32'(c), 32'(vq[i].c));
      chk($sformatf("v%0d_cmp_unsigned", i), 32'(cu), 32'(vq[i].cu));
      chk($sformatf("v%0d_div_zero", i), 32'(dz), 32'(vq[i].dz));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vq[i].lat));
      chk($sformatf("v%0d_in_ready_busy", i), 32'(br), 32'd0);
    end

    // Reset asserted while a result is held in DONE
    @(negedge clk);
    func = 5'b00000; dataIn1 = 32'hFFFFFFFF; dataIn2 = 32'h1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rstdone_pre_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstdone_out_valid", 32'(out_valid), 32'd0);
    chk("rstdone_in_ready", 32'(in_ready), 32'd1);
    chk("rstdone_dataOut", dataOut, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Streaming single-cycle ops with out_ready held high
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    func = 5'b00000; dataIn1 = 32'd1; dataIn2 = 32'd2;
    @(posedge clk); #1;
    chk("stream_add_valid", 32'(out_valid), 32'd1);
    chk("stream_add_data", dataOut, 32'd3);
    func = 5'b00110; dataIn1 = 32'h000000F0; dataIn2 = 32'h000000FF;
    @(posedge clk); #1;
    chk("stream_xor_valid", 32'(out_valid), 32'd1);
    chk("stream_xor_data", dataOut, 32'h0000000F);
    func = 5'b01011; dataIn1 = 32'h0; dataIn2 = 32'h1234ABCD;
    @(posedge clk); #1;
    chk("stream_mvhi_valid", 32'(out_valid), 32'd1);
    chk("stream_mvhi_data", dataOut, 32'h12340000);
    func = 5'b00000; dataIn1 = 32'd9; dataIn2 = 32'd9;
    out_ready = 1'b0;
    #1;
    chk("stall_in_ready_now", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_data", k), dataOut, 32'h12340000);
      chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_data", dataOut, 32'd18);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream_idle_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Operands change and a request is held during BUSY; neither disturbs DIV
    @(negedge clk);
    func = 5'b00011; dataIn1 = 32'd100; dataIn2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    func = 5'b00000; dataIn1 = 32'd1; dataIn2 = 32'd1;
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == 10) dataIn1 = 32'd1;
    end
    chk("hold_div_latency", 32'(n), 32'd33);
    chk("hold_div_data", dataOut, 32'd14);
    @(posedge clk); #1;
    chk("hold_done_stable", dataOut, 32'd14);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_add_accepted", dataOut, 32'd2);
    chk("hold_add_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle combinational ALU in the processor datapath.
- Keeps the existing 5-bit func encoding and adds multi-cycle MUL, DIV and REM.
- Adds a configurable signed/unsigned compare mode and valid/ready handshakes on both sides, so a multi-cycle execute stage can stall on it.

Parameters:
- WIDTH, 32, data width. Must be even and >= 8.
- SIGNED_CMP, 1. 1 = LT/LTE/GT/GTE and the zero compares use two's-complement; 0 = unsigned.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- func  in  5  operation code, {compOrNot, iword[7:4]}
- dataIn1  in  WIDTH  operand A
- dataIn2  in  WIDTH  operand B
- out_valid  out  1  result held and valid
- out_ready  in  1  consumer takes result
- dataOut  out  WIDTH  result
- compTrue  out  1  comparison result
- div_zero  out  1  DIV/REM issued with dataIn2 == 0

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are named clk and reset.
- Reset values: state=IDLE, in_ready=1, out_valid=0, dataOut=0, compTrue=0, div_zero=0. Reset mid-operation aborts the operation and discards any pending result.
- Request accept: func and both operands are captured when in_valid && in_ready.
- FSM states:
  - IDLE: on accept, a single-cycle op goes to DONE; MUL/DIV/REM goes to BUSY with counter = WIDTH.
  - BUSY: one iteration per cycle, counter decrements; at counter==1 → DONE. in_ready=0.
  - DONE: out_valid=1, outputs stable until out_ready. On out_ready with no new accept → IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives back-to-back throughput of 1 op/cycle for single-cycle ops.
- Latency from accept edge to out_valid: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL/DIV/REM.
- Single-cycle ops keep the legacy encodings, generalised to WIDTH:
  - 00000 ADD, 00001 SUB, 00100 AND, 00101 OR, 00110 XOR, 01100 NAND, 01101 NOR, 01110 XNOR.
  - 01011 MVHI: dataIn2 with the low WIDTH/2 bits cleared.
  - 10000 F, 11000 T.
  - 10001 EQ, 10010 LT, 10011 LTE, 11001 NE, 11010 GTE, 11011 GT.
  - 10101 BEQZ, 10110 BLTZ, 10111 BLTEZ, 11101 BNEZ, 11110 BGTEZ, 11111 BGTZ.
- Compare results: dataOut = {WIDTH-1 zeros, compTrue}. Non-compare ops drive compTrue=0.
- Any other code: dataOut=0, compTrue=0, latency 1.
- Overflow: ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
- New multi-cycle ops:
  - 00010 MUL: unsigned shift-add, one bit per cycle; dataOut = low WIDTH bits of the product.
  - 00011 DIV: unsigned restoring division, one quotient bit per cycle; dataOut = quotient.
  - 00111 REM: same datapath as DIV; dataOut = remainder.
- Divide by zero: still takes the full WIDTH+1 cycles. DIV gives all-ones, REM gives dataIn1, and div_zero=1 in DONE. div_zero is 0 for every other op.
- Operand capture: operands are registered at accept, so input changes during BUSY have no effect.
- Ignored requests: in_valid while in_ready=0 is ignored; the requester holds it.

Test Plan:
- Reset, then ADD 0xFFFFFFFF+1 → after 1 cycle: out_valid=1, dataOut=0, compTrue=0. Assert reset mid-DONE → out_valid=0 immediately.
- SIGNED_CMP=1: LT 0xFFFFFFFF vs 1 → compTrue=1, dataOut=1; BLTZ 0x80000000 → compTrue=1. SIGNED_CMP=0: same LT → compTrue=0.
- MUL 0x0001_0003 × 0x0001_0002 → out_valid after 33 cycles, dataOut=0x0005_0006; in_ready=0 throughout BUSY.
- DIV 100/7 → 14; REM 100/7 → 2. DIV 5/0 → 0xFFFFFFFF with div_zero=1; REM 5/0 → 5.
- Back-to-back: out_ready held high while streaming ADD, XOR and MVHI(0x1234ABCD) → one result per cycle, MVHI gives 0x12340000. Holding out_ready=0 for 3 cycles keeps dataOut stable and in_ready=0.
- Undefined func 01000 → dataOut=0, compTrue=0, latency 1.
